// File: rtl/alfa_desc_seg.sv
// alfa_desc_seg -- registered 7-segment letter decoder for the note-entry
// front end. Shows the current note code as C d E F G A b (dash for "no note").
//
// Ports:
//   clk               system clock, rising edge
//   reset             asynchronous, active-high reset (blanks the digit)
//   tom               octave/tone flag (only used for blinking, see below)
//   notas1..notas3    note code N = {notas1, notas2, notas3}
//   saida1..saida7    segments a..g, registered, one cycle after sampling
//
// Parameters:
//   ACTIVE_LOW        1 inverts all segments (common-anode digit)
//   BLINK_DIV         blink counter width (2..32), blink build only
//
// Build option: define ALFA_DESC_SEG_TOM_BLINK_EN to blank the digit while
// tom=1 and the free-running blink counter MSB is 1.

module alfa_desc_seg #(
  parameter bit          ACTIVE_LOW = 1'b0,
  parameter int unsigned BLINK_DIV  = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic tom,
  input  logic notas1,
  input  logic notas2,
  input  logic notas3,
  output logic saida1,
  output logic saida2,
  output logic saida3,
  output logic saida4,
  output logic saida5,
  output logic saida6,
  output logic saida7
);

  if (BLINK_DIV < 2 || BLINK_DIV > 32) begin : g_bad_blink_div
    $error("alfa_desc_seg: BLINK_DIV must be in 2..32");
  end

  // Blank value with output polarity already applied.
  localparam logic [6:0] SEG_BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [2:0] note;
  logic [6:0] glyph;     // {a,b,c,d,e,f,g}, segment lit = 1
  logic [6:0] seg_d;
  logic [6:0] seg_q;

  assign note = {notas1, notas2, notas3};

  always_comb begin
    glyph = 7'b0000001;
    case (note)
      3'b000: glyph = 7'b0000001;  // dash
      3'b001: glyph = 7'b1001110;  // C
      3'b010: glyph = 7'b0111101;  // d
      3'b011: glyph = 7'b1001111;  // E
      3'b100: glyph = 7'b1000111;  // F
      3'b101: glyph = 7'b1011110;  // G
      3'b110: glyph = 7'b1110111;  // A
      3'b111: glyph = 7'b0011111;  // b
      default: glyph = 7'b0000001;
    endcase
  end

`ifdef ALFA_DESC_SEG_TOM_BLINK_EN
  logic [BLINK_DIV-1:0] cnt_d;
  logic [BLINK_DIV-1:0] cnt_q;

  // Counter runs regardless of tom so the blink phase is purely time based.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    seg_d = ACTIVE_LOW ? ~glyph : glyph;
    if (tom && cnt_q[BLINK_DIV-1]) begin
      seg_d = SEG_BLANK;
    end
  end
`else
  // tom has no effect on the glyph in this build.
  logic unused_tom;
  assign unused_tom = tom;

  always_comb begin
    seg_d = ACTIVE_LOW ? ~glyph : glyph;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= SEG_BLANK;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign saida1 = seg_q[6];
  assign saida2 = seg_q[5];
  assign saida3 = seg_q[4];
  assign saida4 = seg_q[3];
  assign saida5 = seg_q[2];
  assign saida6 = seg_q[1];
  assign saida7 = seg_q[0];

endmodule

// File: tb/tb_alfa_desc_seg.sv
// Directed bench for alfa_desc_seg: one active-high and one active-low
// instance share all inputs.
module tb_alfa_desc_seg;

  logic clk;
  logic reset;
  logic tom;
  logic [2:0] n;
  logic [6:0] seg_p;   // ACTIVE_LOW=0 instance, {a..g}
  logic [6:0] seg_n;   // ACTIVE_LOW=1 instance, {a..g}

  int unsigned errors;
  int unsigned checks;

  alfa_desc_seg #(.ACTIVE_LOW(1'b0), .BLINK_DIV(3)) u_dut_p (
    .clk    (clk),
    .reset  (reset),
    .tom    (tom),
    .notas1 (n[2]),
    .notas2 (n[1]),
    .notas3 (n[0]),
    .saida1 (seg_p[6]),
    .saida2 (seg_p[5]),
    .saida3 (seg_p[4]),
    .saida4 (seg_p[3]),
    .saida5 (seg_p[2]),
    .saida6 (seg_p[1]),
    .saida7 (seg_p[0])
  );

  alfa_desc_seg #(.ACTIVE_LOW(1'b1), .BLINK_DIV(3)) u_dut_n (
    .clk    (clk),
    .reset  (reset),
    .tom    (tom),
    .notas1 (n[2]),
    .notas2 (n[1]),
    .notas3 (n[0]),
    .saida1 (seg_n[6]),
    .saida2 (seg_n[5]),
    .saida3 (seg_n[4]),
    .saida4 (seg_n[3]),
    .saida5 (seg_n[2]),
    .saida6 (seg_n[1]),
    .saida7 (seg_n[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_seg(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] sweep_exp [8];

  initial begin
    errors = 0;
    checks = 0;
    sweep_exp[0] = 7'b0000001;
    sweep_exp[1] = 7'b1001110;
    sweep_exp[2] = 7'b0111101;
    sweep_exp[3] = 7'b1001111;
    sweep_exp[4] = 7'b1000111;
    sweep_exp[5] = 7'b1011110;
    sweep_exp[6] = 7'b1110111;
    sweep_exp[7] = 7'b0011111;

    // Reset: blank immediately, no clock edge needed.
    tom   = 1'b0;
    n     = 3'b011;
    reset = 1'b1;
    #1;
    check_seg("reset_p", seg_p, 7'b0000000);
    check_seg("reset_n", seg_n, 7'b1111111);

    @(negedge clk);
    reset = 1'b0;
    #1;
    check_seg("release_hold_p", seg_p, 7'b0000000);
    check_seg("release_hold_n", seg_n, 7'b1111111);

    // Sweep all note codes, one per cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n = 3'(i);
      step();
      check_seg($sformatf("sweep_p_%0d", i), seg_p, sweep_exp[i]);
      check_seg($sformatf("sweep_n_%0d", i), seg_n, ~sweep_exp[i]);
    end

    // Active-low instance showing A.
    @(negedge clk);
    n = 3'b110;
    step();
    check_seg("al_la", seg_n, 7'b0001000);

    // Asynchronous reset between edges while E is shown.
    @(negedge clk);
    n = 3'b011;
    step();
    check_seg("pre_async_mi", seg_p, 7'b1001111);
    #2;
    reset = 1'b1;
    #1;
    check_seg("async_blank_p", seg_p, 7'b0000000);
    check_seg("async_blank_n", seg_n, 7'b1111111);
    @(negedge clk);
    reset = 1'b0;
    step();
    check_seg("post_async_mi", seg_p, 7'b1001111);

`ifdef ALFA_DESC_SEG_TOM_BLINK_EN
    // Restart counter from 0, then tom=1 blinks C with 4-cycle phases.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n     = 3'b001;
    tom   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check_seg($sformatf("blink_p_%0d", i), seg_p, ((i / 4) % 2 == 1) ? 7'b0000000 : 7'b1001110);
      check_seg($sformatf("blink_n_%0d", i), seg_n, ((i / 4) % 2 == 1) ? 7'b1111111 : 7'b0110001);
    end
    @(negedge clk);
    tom = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_seg($sformatf("noblink_%0d", i), seg_p, 7'b1001110);
    end
`else
    // tom toggling has no effect on the glyph.
    @(negedge clk);
    n = 3'b101;
    for (int i = 0; i < 8; i++) begin
      tom = ~tom;
      step();
      check_seg($sformatf("tom_toggle_%0d", i), seg_p, 7'b1011110);
      @(negedge clk);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
